decode_stage_pipelined: RTL
===========================

// Module: decode_stage_pipelined
// PURPOSE
//  Parametrised decode stage: reads operands from an internal register file, decodes the opcode
//  into a control bundle and registers everything into the ID/EX pipeline register. Unlike the
//  first-generation decoder, it adds stall/flush handshakes, load-use hazard bubbles, two-word
//  (long immediate) instruction assembly and same-cycle write-back bypass. Sits between fetch and execute.
// PARAMETERS
//  DATA_W    16  datapath and instruction word width
//  NUM_REGS  8   register-file entries; AW = $clog2(NUM_REGS)
//  OPC_W     5   opcode width, taken from instruction[DATA_W-1 -: OPC_W]
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  reset        in   1        asynchronous, active-high reset
//  instr_valid  in   1        fetch presents a word on instruction
//  instruction  in   DATA_W   instruction word or long-immediate word
//  id_ready     out  1        word accepted this cycle when instr_valid & id_ready
//  flush        in   1        discard the in-flight decode and the ID/EX contents (branch taken)
//  ex_stall     in   1        execute cannot accept; hold the ID/EX register
//  wb_en        in   1        register-file write enable from write-back
//  wb_addr      in   AW       write-back register index
//  wb_data      in   DATA_W   write-back data
//  ex_valid     out  1        ID/EX holds a real instruction (0 = bubble)
//  ex_ctrl      out  CTRL_W   decoded control bundle (layout in decode_pkg)
//  ex_rs_data   out  DATA_W   operand 1 (reg field rs)
//  ex_rt_data   out  DATA_W   operand 2 (reg field rt)
//  ex_rs_addr   out  AW       rs index (for forwarding)
//  ex_rt_addr   out  AW       rt index
//  ex_imm       out  DATA_W   immediate: zero-extended instruction[7:0] or full second word
//  hazard_stall out  1        load-use bubble being inserted this cycle
// BEHAVIOUR
//  Reset: every output, the register file, the ID/EX register and the FSM clear to 0/S_DECODE;
//   id_ready is 0 while reset is high. Reset mid-sequence drops any half-assembled instruction.
//  Fields: rs = instruction[DATA_W-OPC_W-1 -: AW], rt = the next AW bits below rs.
//  Register file: synchronous write on wb_en; combinational read. A read of wb_addr in the
//   same cycle as wb_en returns wb_data (write-before-read bypass).
//  Load-use hazard: hazard_stall = ex_valid & ex_ctrl.mem_read & decoding a word in S_DECODE &
//   (ex_rs_addr == rs | (ex_rs_addr == rt & ~one_operand)). Consumer is not accepted; ID/EX
//   loads a bubble (ex_valid=0, ex_ctrl=0) if ~ex_stall. Exactly one bubble per hazard.
//  id_ready = ~reset & ~ex_stall & ~hazard_stall.
//  FSM S_DECODE: accepted word with ctrl.imm=0 -> ID/EX loads it next edge, ex_valid=1, stay.
//   Accepted word with ctrl.imm=1 -> latch first word and operands, ID/EX loads bubble, go S_IMM.
//  FSM S_IMM: next accepted word is ex_imm; ID/EX loads latched instruction, ex_valid=1, go
//   S_DECODE. No hazard check in S_IMM (operands were checked on the first word).
//  ex_stall=1: ID/EX, latched word and FSM hold; id_ready=0. Latency: one cycle accept->ID/EX.
//  flush=1 (priority over ex_stall and hazard): next edge ex_valid=0, ex_ctrl=0, FSM -> S_DECODE,
//   latched first word discarded; the word presented that cycle is not accepted (id_ready still
//   reports its normal value but acceptance is suppressed).
//  Operands latched at the first word of a two-word instruction use bypass on that cycle; a
//   write-back to that register while in S_IMM also updates the latched operand.
// STRUCTURE
//  decode_pkg: OPC_W-independent opcode localparams, CTRL_W=16 and ctrl field offsets
//   (mem_read, mem_write, wb, alu_op[3:0], dst_sel, push, pop, in_port, out_port, imm,
//   one_operand, jump_type[1:0]), FSM state encodings.
//  Sub-module decode_ctrl: purely combinational opcode -> ctrl bundle; register file, hazard
//   logic, FSM and ID/EX register stay in this module.
// TESTING
//  1 Reset: assert reset mid S_IMM -> all outputs 0, FSM S_DECODE, R0..R7 read 0x0000.
//  2 Bypass: wb_en=1 wb_addr=3 wb_data=0xBEEF while decoding rs=3 -> next cycle ex_rs_data=0xBEEF.
//  3 Load-use: LDD R2 then ADD R1,R2 back-to-back -> hazard_stall=1 for 1 cycle, one bubble,
//    ADD reaches ID/EX one cycle later with correct operands.
//  4 Long immediate: LDM R4 then word 0x1234 -> bubble, then ex_valid=1, ex_imm=0x1234, rs_addr=4.
//  5 Stall: ex_stall=1 for 3 cycles with valid ADD in ID/EX -> outputs unchanged, id_ready=0.
//  6 Flush in S_IMM with ex_stall=1 -> ex_valid=0 next edge, FSM S_DECODE, next word decoded fresh.

Source files
------------

// File: rtl/decode_stage_pipelined_pkg.sv
// Shared decode definitions: opcode numbers, the ID/EX control bundle layout
// and the decode FSM state encoding.
package decode_stage_pipelined_pkg;

  localparam int CTRL_W = 16;

  localparam int OP_NOP  = 0;
  localparam int OP_NOT  = 1;
  localparam int OP_INC  = 2;
  localparam int OP_DEC  = 3;
  localparam int OP_OUT  = 4;
  localparam int OP_IN   = 5;
  localparam int OP_MOV  = 6;
  localparam int OP_ADD  = 7;
  localparam int OP_SUB  = 8;
  localparam int OP_AND  = 9;
  localparam int OP_OR   = 10;
  localparam int OP_SHL  = 11;
  localparam int OP_SHR  = 12;
  localparam int OP_PUSH = 13;
  localparam int OP_POP  = 14;
  localparam int OP_LDM  = 15;
  localparam int OP_LDD  = 16;
  localparam int OP_STD  = 17;
  localparam int OP_JZ   = 18;
  localparam int OP_JMP  = 19;
  localparam int OP_CALL = 20;
  localparam int OP_RET  = 21;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_NOT  = 4'd1;
  localparam logic [3:0] ALU_INC  = 4'd2;
  localparam logic [3:0] ALU_DEC  = 4'd3;
  localparam logic [3:0] ALU_MOV  = 4'd4;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_SHL  = 4'd9;
  localparam logic [3:0] ALU_SHR  = 4'd10;
  localparam logic [3:0] ALU_PASS = 4'd11;

  // Bit offsets of the fields inside the flattened ctrl bundle
  localparam int CTRL_MEM_READ  = 0;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_WB        = 2;
  localparam int CTRL_ALU_OP    = 3;
  localparam int CTRL_DST_SEL   = 7;
  localparam int CTRL_PUSH      = 8;
  localparam int CTRL_POP       = 9;
  localparam int CTRL_IN_PORT   = 10;
  localparam int CTRL_OUT_PORT  = 11;
  localparam int CTRL_IMM       = 12;
  localparam int CTRL_ONE_OP    = 13;
  localparam int CTRL_JUMP_TYPE = 14;

  typedef struct packed {
    logic [1:0] jump_type;
    logic       one_operand;
    logic       imm;
    logic       out_port;
    logic       in_port;
    logic       pop;
    logic       push;
    logic       dst_sel;
    logic [3:0] alu_op;
    logic       wb;
    logic       mem_write;
    logic       mem_read;
  } ctrl_t;

  typedef enum logic {
    S_DECODE = 1'b0,
    S_IMM    = 1'b1
  } state_t;

endpackage

// File: rtl/decode_stage_pipelined_if.sv
// Fetch / write-back / execute side signals of the decode stage.
interface decode_stage_pipelined_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
);
  localparam int AW = $clog2(NUM_REGS);

  logic                                      instr_valid;
  logic [DATA_W-1:0]                         instruction;
  logic                                      id_ready;
  logic                                      flush;
  logic                                      ex_stall;
  logic                                      wb_en;
  logic [AW-1:0]                             wb_addr;
  logic [DATA_W-1:0]                         wb_data;
  logic                                      ex_valid;
  logic [decode_stage_pipelined_pkg::CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0]                         ex_rs_data;
  logic [DATA_W-1:0]                         ex_rt_data;
  logic [AW-1:0]                             ex_rs_addr;
  logic [AW-1:0]                             ex_rt_addr;
  logic [DATA_W-1:0]                         ex_imm;
  logic                                      hazard_stall;

  modport master (
    output instr_valid, instruction, flush, ex_stall, wb_en, wb_addr, wb_data,
    input  id_ready, ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_rs_addr,
           ex_rt_addr, ex_imm, hazard_stall
  );

  modport slave (
    input  instr_valid, instruction, flush, ex_stall, wb_en, wb_addr, wb_data,
    output id_ready, ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_rs_addr,
           ex_rt_addr, ex_imm, hazard_stall
  );
endinterface

// File: rtl/decode_ctrl.sv
// Combinational opcode -> control bundle lookup.
module decode_ctrl
  import decode_stage_pipelined_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] i_opcode,
  output ctrl_t            o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (int'(i_opcode))
      OP_NOT:  begin o_ctrl.wb = 1'b1; o_ctrl.alu_op = ALU_NOT; o_ctrl.one_operand = 1'b1; end
      OP_INC:  begin o_ctrl.wb = 1'b1; o_ctrl.alu_op = ALU_INC; o_ctrl.one_operand = 1'b1; end
      OP_DEC:  begin o_ctrl.wb = 1'b1; o_ctrl.alu_op = ALU_DEC; o_ctrl.one_operand = 1'b1; end
      OP_OUT:  begin o_ctrl.out_port = 1'b1; o_ctrl.one_operand = 1'b1; end
      OP_IN:   begin o_ctrl.in_port = 1'b1; o_ctrl.wb = 1'b1; o_ctrl.one_operand = 1'b1; end
      OP_MOV:  begin o_ctrl.wb = 1'b1; o_ctrl.alu_op = ALU_MOV; o_ctrl.dst_sel = 1'b1; end
      OP_ADD:  begin o_ctrl.wb = 1'b1; o_ctrl.alu_op = ALU_ADD; end
      OP_SUB:  begin o_ctrl.wb = 1'b1; o_ctrl.alu_op = ALU_SUB; end
      OP_AND:  begin o_ctrl.wb = 1'b1; o_ctrl.alu_op = ALU_AND; end
      OP_OR:   begin o_ctrl.wb = 1'b1; o_ctrl.alu_op = ALU_OR;  end
      OP_SHL:  begin o_ctrl.wb = 1'b1; o_ctrl.alu_op = ALU_SHL; o_ctrl.one_operand = 1'b1; end
      OP_SHR:  begin o_ctrl.wb = 1'b1; o_ctrl.alu_op = ALU_SHR; o_ctrl.one_operand = 1'b1; end
      OP_PUSH: begin o_ctrl.push = 1'b1; o_ctrl.mem_write = 1'b1; o_ctrl.one_operand = 1'b1; end
      OP_POP:  begin
        o_ctrl.pop = 1'b1; o_ctrl.mem_read = 1'b1; o_ctrl.wb = 1'b1; o_ctrl.one_operand = 1'b1;
      end
      // LDM is the only two-word instruction: its immediate is the next fetched word
      OP_LDM:  begin
        o_ctrl.wb = 1'b1; o_ctrl.alu_op = ALU_PASS; o_ctrl.imm = 1'b1; o_ctrl.one_operand = 1'b1;
      end
      OP_LDD:  begin o_ctrl.mem_read = 1'b1; o_ctrl.wb = 1'b1; o_ctrl.one_operand = 1'b1; end
      OP_STD:  begin o_ctrl.mem_write = 1'b1; o_ctrl.one_operand = 1'b1; end
      OP_JZ:   begin o_ctrl.jump_type = 2'd1; o_ctrl.one_operand = 1'b1; end
      OP_JMP:  begin o_ctrl.jump_type = 2'd2; o_ctrl.one_operand = 1'b1; end
      OP_CALL: begin
        o_ctrl.jump_type = 2'd3; o_ctrl.push = 1'b1; o_ctrl.mem_write = 1'b1; o_ctrl.one_operand = 1'b1;
      end
      OP_RET:  begin
        o_ctrl.jump_type = 2'd2; o_ctrl.pop = 1'b1; o_ctrl.mem_read = 1'b1; o_ctrl.one_operand = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage_pipelined.sv
// Decode stage: register file with write-back bypass, load-use bubbles,
// two-word immediate assembly and the ID/EX pipeline register.
module decode_stage_pipelined
  import decode_stage_pipelined_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int OPC_W    = 5
) (
  input logic                     clk,
  input logic                     reset,
  decode_stage_pipelined_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [OPC_W-1:0]  w_opc;
  logic [AW-1:0]     w_rs, w_rt;
  ctrl_t             w_ctrl;
  logic [DATA_W-1:0] w_rs_data, w_rt_data, w_lat_rs_fwd, w_lat_rt_fwd;
  logic              w_hazard, w_id_ready, w_accept;
  logic              w_load_cur, w_latch_first, w_load_lat;
  state_t            r_state, w_state_nxt;

  logic [DATA_W-1:0] r_rf [NUM_REGS];

  logic [AW-1:0]     r_lat_rs_addr, r_lat_rt_addr;
  logic [DATA_W-1:0] r_lat_rs_data, r_lat_rt_data;
  ctrl_t             r_lat_ctrl;

  logic              r_ex_valid;
  ctrl_t             r_ex_ctrl;
  logic [DATA_W-1:0] r_ex_rs_data, r_ex_rt_data, r_ex_imm;
  logic [AW-1:0]     r_ex_rs_addr, r_ex_rt_addr;

  assign w_opc = bus.instruction[DATA_W-1 -: OPC_W];
  assign w_rs  = bus.instruction[DATA_W-OPC_W-1 -: AW];
  assign w_rt  = bus.instruction[DATA_W-OPC_W-AW-1 -: AW];

  decode_ctrl #(.OPC_W(OPC_W)) u_ctrl (
    .i_opcode (w_opc),
    .o_ctrl   (w_ctrl)
  );

  // Register file read with same-cycle write-back bypass
  assign w_rs_data = (bus.wb_en && bus.wb_addr == w_rs) ? bus.wb_data : r_rf[w_rs];
  assign w_rt_data = (bus.wb_en && bus.wb_addr == w_rt) ? bus.wb_data : r_rf[w_rt];
  assign w_lat_rs_fwd = (bus.wb_en && bus.wb_addr == r_lat_rs_addr) ? bus.wb_data : r_lat_rs_data;
  assign w_lat_rt_fwd = (bus.wb_en && bus.wb_addr == r_lat_rt_addr) ? bus.wb_data : r_lat_rt_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else if (bus.wb_en) begin
      r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign w_hazard = r_ex_valid & r_ex_ctrl.mem_read & bus.instr_valid & (r_state == S_DECODE) &
                    ((r_ex_rs_addr == w_rs) | ((r_ex_rs_addr == w_rt) & ~w_ctrl.one_operand));
  assign w_id_ready = ~reset & ~bus.ex_stall & ~w_hazard;
  assign w_accept   = bus.instr_valid & w_id_ready & ~bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_DECODE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = S_DECODE;
    end else begin
      case (r_state)
        S_DECODE: if (w_latch_first) w_state_nxt = S_IMM;
        S_IMM:    if (w_load_lat)    w_state_nxt = S_DECODE;
        default:  w_state_nxt = S_DECODE;
      endcase
    end
  end

  always_comb begin
    w_load_cur    = 1'b0;
    w_latch_first = 1'b0;
    w_load_lat    = 1'b0;
    case (r_state)
      S_DECODE: begin
        w_load_cur    = w_accept & ~w_ctrl.imm;
        w_latch_first = w_accept &  w_ctrl.imm;
      end
      S_IMM:   w_load_lat = w_accept;
      default: ;
    endcase
  end

  // First word of a two-word instruction; operands track write-back while waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lat_ctrl    <= '0;
      r_lat_rs_addr <= '0;
      r_lat_rt_addr <= '0;
      r_lat_rs_data <= '0;
      r_lat_rt_data <= '0;
    end else if (w_latch_first) begin
      r_lat_ctrl    <= w_ctrl;
      r_lat_rs_addr <= w_rs;
      r_lat_rt_addr <= w_rt;
      r_lat_rs_data <= w_rs_data;
      r_lat_rt_data <= w_rt_data;
    end else if (r_state == S_IMM) begin
      r_lat_rs_data <= w_lat_rs_fwd;
      r_lat_rt_data <= w_lat_rt_fwd;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid   <= 1'b0;
      r_ex_ctrl    <= '0;
      r_ex_rs_data <= '0;
      r_ex_rt_data <= '0;
      r_ex_rs_addr <= '0;
      r_ex_rt_addr <= '0;
      r_ex_imm     <= '0;
    end else if (bus.flush) begin
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
    end else if (!bus.ex_stall) begin
      if (w_load_cur) begin
        r_ex_valid   <= 1'b1;
        r_ex_ctrl    <= w_ctrl;
        r_ex_rs_data <= w_rs_data;
        r_ex_rt_data <= w_rt_data;
        r_ex_rs_addr <= w_rs;
        r_ex_rt_addr <= w_rt;
        r_ex_imm     <= {{(DATA_W-8){1'b0}}, bus.instruction[7:0]};
      end else if (w_load_lat) begin
        r_ex_valid   <= 1'b1;
        r_ex_ctrl    <= r_lat_ctrl;
        r_ex_rs_data <= w_lat_rs_fwd;
        r_ex_rt_data <= w_lat_rt_fwd;
        r_ex_rs_addr <= r_lat_rs_addr;
        r_ex_rt_addr <= r_lat_rt_addr;
        r_ex_imm     <= bus.instruction;
      end else begin
        r_ex_valid <= 1'b0;
        r_ex_ctrl  <= '0;
      end
    end
  end

  assign bus.id_ready     = w_id_ready;
  assign bus.hazard_stall = w_hazard;
  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_ctrl      = r_ex_ctrl;
  assign bus.ex_rs_data   = r_ex_rs_data;
  assign bus.ex_rt_data   = r_ex_rt_data;
  assign bus.ex_rs_addr   = r_ex_rs_addr;
  assign bus.ex_rt_addr   = r_ex_rt_addr;
  assign bus.ex_imm       = r_ex_imm;

endmodule
